fir_tx_code_gen: RTL
====================

// Module: fir_tx_code_gen
// PURPOSE
//  Transmit-side excitation generator; the emitter whose output the receive FIR matched filter correlates against.
//  On start, emits NUM_BURSTS bursts of a CODE_LEN-chip binary phase code as signed 32-bit samples (+/-AMPLITUDE).
//  Bursts are separated by a programmable idle gap. One sample per CLK; same sample format as the FIR data path.
// PARAMETERS
//  CODE_LEN   13        chips per burst (1..32)
//  CODE_BITS  13'h1F35  chip pattern, MSB emitted first; 1 -> +AMPLITUDE, 0 -> -AMPLITUDE (Barker-13)
//  AMPLITUDE  362       chip magnitude, positive, < 2^31
//  REP_W      8         width of burst-count input
//  GAP_W      16        width of gap-length input
// PORTS
//  CLK        in   1      clock, all logic on rising edge
//  reset      in   1      synchronous, active-high
//  start      in   1      begin sequence; sampled only in IDLE
//  abort      in   1      terminate sequence at next edge
//  numBursts  in   REP_W  bursts per sequence, latched on accepted start
//  gapLen     in   GAP_W  idle cycles between bursts, latched on accepted start
//  outData    out  32     signed sample, registered
//  outValid   out  1      outData holds a chip
//  busy       out  1      sequence in progress
//  done       out  1      one-cycle pulse at normal completion
// BEHAVIOUR
//  Reset: state IDLE; outData=0, outValid=0, busy=0, done=0; counters and latched inputs cleared.
//  States: IDLE -> EMIT -> (GAP -> EMIT)* -> IDLE.
//  IDLE: start=1 at edge n, numBursts!=0 -> latch inputs, go EMIT; chip 0 on outData, outValid=1, busy=1 from edge n+1.
//  start with numBursts=0: no samples; done=1 for the cycle after edge n; busy stays 0.
//  EMIT: one chip per cycle, chip index 0..CODE_LEN-1, MSB of CODE_BITS first; burst occupies exactly CODE_LEN cycles.
//  End of burst: if more bursts and gapLen>0 -> GAP; gapLen=0 -> next burst's chip 0 on the immediately following cycle.
//  GAP: exactly gapLen cycles with outValid=0, outData=0, busy=1.
//  Last chip of last burst: next cycle outValid=0, outData=0, busy=0, done=1 (one cycle), state IDLE.
//  Total busy cycles = numBursts*CODE_LEN + (numBursts-1)*gapLen.
//  start while busy: ignored, no queuing. A new start may be accepted in the same cycle done is high.
//  abort=1 in any state: next edge -> IDLE, outData=0, outValid=0, busy=0; done NOT asserted. abort wins over a simultaneous start.
//  reset mid-sequence: identical to reset values; no done.
//  Arithmetic: sample = chip ? AMPLITUDE : -AMPLITUDE, two's complement, sign-extended to 32 bits; no saturation needed.
//  Burst counter width REP_W, gap counter width GAP_W; max values (255, 65535) valid without wrap.
// CONFIGURATION
//  TX_PULSE_INVERT_EN defined: bursts alternate polarity; even-index bursts (0,2,..) normal, odd-index bursts negated chip-for-chip.
//  Not defined: every burst uses the same polarity. Timing identical in both builds.
// STRUCTURE
//  Package fir_tx_pkg: state encoding (IDLE, EMIT, GAP), default CODE_BITS/CODE_LEN constants, AMPLITUDE default.
//  One sub-module: fir_tx_chip_map -- combinational chip index + polarity -> signed 32-bit sample.
//  Top holds FSM, chip/burst/gap counters, latched inputs and the output registers.
// TESTING
//  1. Reset, start=1, numBursts=1, gapLen=0 -> 13 valid cycles: 362 x5, -362 (32'hFFFFFE96) x2, 362 x2, -362, 362, -362, 362; then done=1 one cycle.
//  2. numBursts=3, gapLen=4 -> 13 valid, 4 invalid zero, 13, 4, 13; busy=47 cycles; one done pulse.
//  3. numBursts=2, gapLen=0 -> 26 contiguous valid chips; with TX_PULSE_INVERT_EN chips 13..25 negated, else repeat of 0..12.
//  4. abort asserted at chip 5 of burst 1 -> next cycle outValid=0, busy=0, done stays 0; following start runs normally.
//  5. start with numBursts=0 -> no outValid; done=1 exactly one cycle after start; busy never asserted.
//  6. start pulsed mid-sequence and reset asserted at chip 7 -> restart ignored; reset gives all outputs 0 next cycle, no done.

Source files
------------

// File: rtl/fir_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_tx_pkg
// Description : Shared state encoding and default code constants for the
//               transmit code generator.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_tx_pkg;

    localparam int          c_CODE_LEN    = 13;
    localparam logic [31:0] c_CODE_BITS   = 32'h0000_1F35;  // Barker-13
    localparam int          c_AMPLITUDE   = 362;
    localparam int          c_CHIP_IDX_W  = 5;              // covers CODE_LEN up to 32

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2
    } txState_t;

endpackage
`default_nettype wire

// File: rtl/fir_tx_chip_map.sv
`default_nettype none
// ============================================================================
// Module      : fir_tx_chip_map
// Description : Combinational chip index + polarity to signed 32-bit sample.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_tx_chip_map
    import fir_tx_pkg::*;
#(
    parameter int          CODE_LEN  = c_CODE_LEN,
    parameter logic [31:0] CODE_BITS = c_CODE_BITS,
    parameter int          AMPLITUDE = c_AMPLITUDE
) (
    input  logic [c_CHIP_IDX_W-1:0] chipIdx,
    input  logic                    invert,
    output logic signed [31:0]      sample
);

    localparam logic [c_CHIP_IDX_W-1:0] c_LAST_CHIP = c_CHIP_IDX_W'(CODE_LEN - 1);
    localparam logic signed [31:0]      c_POS       = 32'(AMPLITUDE);
    localparam logic signed [31:0]      c_NEG       = -c_POS;

    logic [c_CHIP_IDX_W-1:0] w_bitPos;
    logic                    w_chip;

    // Chip 0 is the MSB of the active code field.
    always_comb begin
        w_bitPos = c_LAST_CHIP - chipIdx;
        w_chip   = CODE_BITS[w_bitPos] ^ invert;
        sample   = w_chip ? c_POS : c_NEG;
    end

endmodule
`default_nettype wire

// File: rtl/fir_tx_code_gen.sv
`default_nettype none
// ============================================================================
// Module      : fir_tx_code_gen
// Description : Emits NUM_BURSTS bursts of a binary phase code separated by a
//               programmable idle gap. Define TX_PULSE_INVERT_EN to negate
//               every odd-index burst.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_tx_code_gen
    import fir_tx_pkg::*;
#(
    parameter int          CODE_LEN  = c_CODE_LEN,
    parameter logic [31:0] CODE_BITS = c_CODE_BITS,
    parameter int          AMPLITUDE = c_AMPLITUDE,
    parameter int          REP_W     = 8,
    parameter int          GAP_W     = 16
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [REP_W-1:0]    numBursts,
    input  logic [GAP_W-1:0]    gapLen,
    output logic signed [31:0]  outData,
    output logic                outValid,
    output logic                busy,
    output logic                done
);

    localparam logic [c_CHIP_IDX_W-1:0] c_LAST_CHIP = c_CHIP_IDX_W'(CODE_LEN - 1);

    txState_t                r_state;
    logic [c_CHIP_IDX_W-1:0] r_chipIdx;
    logic [REP_W-1:0]        r_burstIdx;
    logic [REP_W-1:0]        r_numBursts;
    logic [GAP_W-1:0]        r_gapLen;
    logic [GAP_W-1:0]        r_gapCnt;

    logic [c_CHIP_IDX_W-1:0] w_nextIdx;
    logic                    w_invert;
    logic signed [31:0]      w_sample;

    // Index and polarity of the chip that would be loaded at the next edge.
    always_comb begin
        w_nextIdx = '0;
        w_invert  = 1'b0;
        if (r_state == ST_EMIT && r_chipIdx != c_LAST_CHIP) begin
            w_nextIdx = r_chipIdx + c_CHIP_IDX_W'(1);
        end
`ifdef TX_PULSE_INVERT_EN
        if (r_state == ST_EMIT && r_chipIdx != c_LAST_CHIP) begin
            w_invert = r_burstIdx[0];
        end else if (r_state != ST_IDLE) begin
            w_invert = ~r_burstIdx[0];
        end
`endif
    end

    fir_tx_chip_map #(
        .CODE_LEN  (CODE_LEN),
        .CODE_BITS (CODE_BITS),
        .AMPLITUDE (AMPLITUDE)
    ) u_chipMap (
        .chipIdx (w_nextIdx),
        .invert  (w_invert),
        .sample  (w_sample)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_chipIdx   <= '0;
            r_burstIdx  <= '0;
            r_numBursts <= '0;
            r_gapLen    <= '0;
            r_gapCnt    <= '0;
            outData     <= '0;
            outValid    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                r_state  <= ST_IDLE;
                outData  <= '0;
                outValid <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            if (numBursts == '0) begin
                                done <= 1'b1;
                            end else begin
                                r_numBursts <= numBursts;
                                r_gapLen    <= gapLen;
                                r_chipIdx   <= '0;
                                r_burstIdx  <= '0;
                                r_state     <= ST_EMIT;
                                outData     <= w_sample;
                                outValid    <= 1'b1;
                                busy        <= 1'b1;
                            end
                        end
                    end
                    ST_EMIT: begin
                        if (r_chipIdx != c_LAST_CHIP) begin
                            r_chipIdx <= w_nextIdx;
                            outData   <= w_sample;
                        end else if (r_burstIdx == r_numBursts - REP_W'(1)) begin
                            r_state  <= ST_IDLE;
                            outData  <= '0;
                            outValid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else if (r_gapLen == '0) begin
                            r_chipIdx  <= '0;
                            r_burstIdx <= r_burstIdx + REP_W'(1);
                            outData    <= w_sample;
                        end else begin
                            r_state  <= ST_GAP;
                            r_gapCnt <= r_gapLen - GAP_W'(1);
                            outData  <= '0;
                            outValid <= 1'b0;
                        end
                    end
                    ST_GAP: begin
                        if (r_gapCnt == '0) begin
                            r_state    <= ST_EMIT;
                            r_chipIdx  <= '0;
                            r_burstIdx <= r_burstIdx + REP_W'(1);
                            outData    <= w_sample;
                            outValid   <= 1'b1;
                        end else begin
                            r_gapCnt <= r_gapCnt - GAP_W'(1);
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        outData  <= '0;
                        outValid <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
